prog_clk_divider: RTL and testbench
===================================

# prog_clk_divider

Runtime-programmable integer clock divider producing a 50%-duty output for both odd and even ratios. It generalises the fixed odd-ratio divider: the ratio is a WIDTH-bit runtime value, changes are glitch-free at period boundaries, and start/stop is gated. It sits in the clock-generation area and drives low-rate peripheral clocks plus a period tick for the synchronous logic on clk.

## Interface
- WIDTH, 8, width of the ratio and counter; supported ratios are 2 .. 2^WIDTH-1.
- RESET_RATIO, 3, ratio loaded at reset; must be >= 2.

- clk  in  1  source clock; the counter uses the rising edge and the half-cycle register uses the falling edge.
- rst  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low).
- enable  in  1  run request; level-sensitive.
- div_ratio  in  WIDTH  requested ratio N; sampled only when div_load=1.
- div_load  in  1  single-cycle strobe that captures div_ratio.
- clk_out  out  1  divided clock.
- period_tick  out  1  one-clk pulse, high in the cycle where cnt==0 while running.
- active  out  1  high while the divider is in RUN or STOP.
- cur_ratio  out  WIDTH  ratio currently in effect.
- load_err  out  1  one-cycle pulse when a load is rejected.

## Operation
- States: IDLE, RUN, STOP.
  - IDLE: cnt=0, hi_p=0, clk_out=0. enable=1 goes to RUN.
  - RUN: cnt counts 0..N-1 and wraps. At a wrap, enable=0 ends the run (see STOP).
  - STOP: entered when enable=0 is sampled mid-period. The current period finishes. At the wrap the block goes to IDLE. enable=1 during STOP returns to RUN with no disturbance.
- If enable=0 is sampled at the wrap edge itself, the block goes straight to IDLE.
- H = ceil(N/2).
- hi_p is a posedge register equal to (cnt < H) for the current cnt. hi_n is hi_p captured on the falling edge.
- clk_out = hi_p when N is even; clk_out = hi_p & hi_n when N is odd.
- Resulting high time is N/2 clk periods for both even and odd N.
- Ratio loading:
  - div_load with div_ratio >= 2 writes a pending register. A newer load overwrites an unapplied one.
  - div_load with div_ratio < 2 is ignored: pending is unchanged and load_err pulses the next cycle.
  - In IDLE, pending is applied on the next edge.
  - In RUN or STOP, pending is applied at the wrap edge (cnt==N-1 -> 0). A load on the same edge as the wrap is applied at the following wrap.
  - cur_ratio updates on the edge where the ratio is applied.
- The counter compares with cur_ratio-1 at WIDTH bits. No partial period is ever emitted.

## Timing
- On rst=0 at a posedge:
  - state=IDLE, cnt=0, cur_ratio=RESET_RATIO, pending is cleared, hi_p=0.
  - clk_out=0, period_tick=0, active=0, load_err=0.
- hi_n clears at the next falling edge while rst=0.
- Reset mid-period forces clk_out low within half a clk period. No pulse is emitted afterward until enable is sampled again.
- Start: enable=1 sampled at posedge k in IDLE gives the following at edge k:
  - cnt=0, hi_p=1, active=1.
  - period_tick is high in cycle k.
  - Even N: clk_out rises at edge k.
  - Odd N: clk_out rises at the falling edge k+0.5.
- The last clk_out falling edge occurs at edge k+H of the final period. active drops at the wrap edge.
- Steady state: one clk_out period per N clk periods, and period_tick repeats every N cycles.

## Test plan
- Reset with N=3, enable=1: clk_out is high for 1.5 clk and low for 1.5; period_tick every 3 cycles. rst=0 mid-high drives clk_out low within 0.5 clk and all outputs 0.
- Load 4, 5, 2, 255 in sequence from IDLE, enable=1: measured high/low times (in clk periods) are 2/2, 2.5/2.5, 1/1 and 127.5/127.5.
- N=6 running, load 3 at cnt=2: the current 6-cycle period completes. The next period is 3 cycles, and cur_ratio becomes 3 exactly at the wrap edge.
- Load 5 on the wrap edge while running N=4: one more 4-cycle period follows, then 5-cycle periods.
- Load 0 and 1 while running N=4: load_err pulses once per load; cur_ratio and the period stay at 4.
- N=7, drop enable at cnt=1: the period completes (7 cycles) and active falls at the wrap. Repeat the test but re-raise enable at cnt=4: no gap and no stop occur.

Source files
------------

// File: rtl/prog_clk_divider_if.sv
// ---------------------------------------------------------------------------
// prog_clk_divider_if
//   Control/status bundle of the programmable clock divider.
//   master : drives the run request and ratio loads, observes the outputs.
//   slave  : the divider itself.
//   Signals:
//     enable      run request (level)
//     div_ratio   requested ratio N, captured when div_load=1
//     div_load    single-cycle load strobe
//     clk_out     divided 50%-duty clock
//     period_tick one-clk pulse at the start of each output period
//     active      divider is running or finishing its last period
//     cur_ratio   ratio currently in effect
//     load_err    one-cycle pulse after a rejected load (ratio < 2)
// ---------------------------------------------------------------------------
interface prog_clk_divider_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic [WIDTH-1:0] div_ratio;
    logic             div_load;
    logic             clk_out;
    logic             period_tick;
    logic             active;
    logic [WIDTH-1:0] cur_ratio;
    logic             load_err;

    modport master (
        output enable, div_ratio, div_load,
        input  clk_out, period_tick, active, cur_ratio, load_err
    );

    modport slave (
        input  enable, div_ratio, div_load,
        output clk_out, period_tick, active, cur_ratio, load_err
    );
endinterface

// File: rtl/prog_clk_divider.sv
// ---------------------------------------------------------------------------
// prog_clk_divider
//   Runtime-programmable integer clock divider with 50% duty for odd and even
//   ratios. Ratio changes take effect only at period boundaries; start/stop is
//   gated so no partial period is ever emitted.
//   Ports:
//     clk  source clock (counter on rising edge, half-cycle flop on falling)
//     rst  synchronous active-low reset
//     bus  prog_clk_divider_if.slave (enable, div_ratio, div_load in;
//          clk_out, period_tick, active, cur_ratio, load_err out)
// ---------------------------------------------------------------------------
module prog_clk_divider #(
    parameter int WIDTH       = 8,
    parameter int RESET_RATIO = 3
) (
    input  logic                clk,
    input  logic                rst,
    prog_clk_divider_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] RATIO_RST = WIDTH'(RESET_RATIO);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO       = WIDTH'(2);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cur_ratio_q, cur_ratio_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             hi_p_q, hi_p_d;
    logic             hi_n_q;
    logic             load_err_q, load_err_d;

    logic             wrap;
    logic             load_ok;
    logic             apply;
    logic [WIDTH-1:0] half_d;

    // Last cycle of a running period; IDLE never wraps.
    assign wrap    = (state_q != IDLE) && (cnt_q == cur_ratio_q - ONE);
    assign load_ok = bus.div_load && (bus.div_ratio >= TWO);
    // A pending ratio lands immediately when idle, otherwise only at a wrap.
    assign apply   = pend_vld_q && ((state_q == IDLE) || wrap);

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_ratio_d = apply ? pend_q : cur_ratio_q;
        pend_d      = pend_q;
        pend_vld_d  = pend_vld_q;
        load_err_d  = bus.div_load && !load_ok;

        // A fresh load wins over clearing: it stays pending for the next boundary.
        if (load_ok) begin
            pend_d     = bus.div_ratio;
            pend_vld_d = 1'b1;
        end else if (apply) begin
            pend_vld_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.enable) state_d = RUN;
            end
            RUN: begin
                cnt_d = wrap ? '0 : cnt_q + ONE;
                if (!bus.enable) state_d = wrap ? IDLE : STOP;
            end
            STOP: begin
                cnt_d = wrap ? '0 : cnt_q + ONE;
                if (bus.enable)  state_d = RUN;
                else if (wrap)   state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // H = ceil(N/2) of the ratio that will be in effect for cnt_d.
        half_d = (cur_ratio_d >> 1) + {{(WIDTH-1){1'b0}}, cur_ratio_d[0]};
        hi_p_d = (state_d != IDLE) && (cnt_d < half_d);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the pre-edge value of its inputs.
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cur_ratio_q <= RATIO_RST;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            hi_p_q      <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_ratio_q <= cur_ratio_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            hi_p_q      <= hi_p_d;
            load_err_q  <= load_err_d;
        end
    end

    // Half-cycle delayed copy of hi_p; ANDing it in for odd N trims the
    // leading half cycle so the high time is exactly N/2 clocks.
    always_ff @(negedge clk) begin
        if (!rst) hi_n_q <= 1'b0;
        else      hi_n_q <= hi_p_q;
    end

    // At a ratio change both hi_p and hi_n are low, so switching the parity
    // select at the wrap edge cannot glitch.
    assign bus.clk_out     = cur_ratio_q[0] ? (hi_p_q & hi_n_q) : hi_p_q;
    assign bus.period_tick = (state_q != IDLE) && (cnt_q == '0);
    assign bus.active      = (state_q != IDLE);
    assign bus.cur_ratio   = cur_ratio_q;
    assign bus.load_err    = load_err_q;

endmodule

// File: tb/tb_prog_clk_divider.sv
// ---------------------------------------------------------------------------
// tb_prog_clk_divider
//   Scoreboard bench: each scenario pushes the output periods it expects
//   (ratio and tick spacing); a monitor sampling every half clock pops them
//   at each period_tick and measures clk_out high/low times in half cycles.
// ---------------------------------------------------------------------------
module tb_prog_clk_divider;

    localparam int WIDTH = 8;

    typedef struct {
        int n;         // ratio expected for this period
        int interval;  // clk cycles since previous tick, 0 = first of a run
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    prog_clk_divider_if #(.WIDTH(WIDTH)) bus ();

    prog_clk_divider #(.WIDTH(WIDTH), .RESET_RATIO(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int   err_cnt = 0;
    int   chk_cnt = 0;
    exp_t sb_q[$];

    // monitor state
    bit   mon_en     = 1'b1;
    int   h          = 0;
    int   last_tick_h = 0;
    int   rise_h     = 0;
    int   last_fall_h = 0;
    int   prev_n     = 0;
    int   cur_n      = 0;
    int   low_exp    = 0;
    bit   low_armed  = 1'b0;
    bit   high_armed = 1'b0;
    logic last_out   = 1'b0;

    task automatic check(input string tag, input int actual, input int expected);
        chk_cnt++;
        if (actual !== expected) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic push(input int n, input int interval);
        exp_t e;
        e.n        = n;
        e.interval = interval;
        sb_q.push_back(e);
    endtask

    task automatic mon_sample(input bit at_pos);
        exp_t e;
        h++;
        if (at_pos && bus.period_tick === 1'b1) begin
            if (mon_en) begin
                check("tick_expected", int'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("tick_ratio", int'(bus.cur_ratio), e.n);
                    if (e.interval != 0) begin
                        check("tick_interval", (h - last_tick_h) / 2, e.interval);
                        // low = previous high-to-next-rise, shifted by the
                        // half-cycle rise delay of odd ratios
                        low_exp   = prev_n + (e.n % 2) - (prev_n % 2);
                        low_armed = 1'b1;
                    end else begin
                        low_armed = 1'b0;
                    end
                    prev_n = e.n;
                    cur_n  = e.n;
                end
            end
            last_tick_h = h;
        end
        if (bus.clk_out === 1'b1 && last_out === 1'b0) begin
            if (mon_en && low_armed) check("low_halves", h - last_fall_h, low_exp);
            low_armed  = 1'b0;
            rise_h     = h;
            high_armed = mon_en;
        end else if (bus.clk_out === 1'b0 && last_out === 1'b1) begin
            if (mon_en && high_armed) check("high_halves", h - rise_h, cur_n);
            high_armed  = 1'b0;
            last_fall_h = h;
        end
        last_out = bus.clk_out;
    endtask

    initial begin
        forever begin
            @(posedge clk); #1; mon_sample(1'b1);
            @(negedge clk); #1; mon_sample(1'b0);
        end
    end

    // Advance to 1 time unit after the n-th following falling edge.
    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic load_ratio(input int n);
        bus.div_ratio = WIDTH'(n);
        bus.div_load  = 1'b1;
        tick_n(1);
        bus.div_load  = 1'b0;
        tick_n(1);
        check("idle_load_applied", int'(bus.cur_ratio), n);
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_active"}, int'(bus.active), 0);
        check({tag, "_sb_empty"}, sb_q.size(), 0);
    endtask

    // Run p full periods of ratio n from IDLE, then stop mid-period.
    task automatic run_ratio(input int n, input int p);
        load_ratio(n);
        push(n, 0);
        for (int i = 1; i < p; i++) push(n, n);
        bus.enable = 1'b1;
        tick_n((p - 1) * n + 1);
        bus.enable = 1'b0;
        tick_n(n + 2);
        expect_idle("run");
    endtask

    initial begin
        rst           = 1'b0;
        bus.enable    = 1'b0;
        bus.div_load  = 1'b0;
        bus.div_ratio = '0;
        tick_n(3);
        check("rst_clk_out", int'(bus.clk_out), 0);
        check("rst_tick", int'(bus.period_tick), 0);
        check("rst_active", int'(bus.active), 0);
        check("rst_load_err", int'(bus.load_err), 0);
        check("rst_ratio", int'(bus.cur_ratio), 3);

        // N=3 from reset, then reset while clk_out is high
        push(3, 0);
        for (int i = 0; i < 3; i++) push(3, 3);
        rst        = 1'b1;
        bus.enable = 1'b1;
        tick_n(10);
        rst    = 1'b0;
        mon_en = 1'b0;
        tick_n(1);
        check("midrst_clk_out", int'(bus.clk_out), 0);
        check("midrst_active", int'(bus.active), 0);
        check("midrst_tick", int'(bus.period_tick), 0);
        check("midrst_load_err", int'(bus.load_err), 0);
        bus.enable = 1'b0;
        tick_n(2);
        rst = 1'b1;
        tick_n(3);
        check("post_rst_clk_out", int'(bus.clk_out), 0);
        check("post_rst_ratio", int'(bus.cur_ratio), 3);
        mon_en = 1'b1;
        expect_idle("post_rst");

        // ratio sweep from IDLE
        run_ratio(4, 3);
        run_ratio(5, 3);
        run_ratio(2, 3);
        run_ratio(255, 2);

        // N=6 running, load 3 while cnt==2
        load_ratio(6);
        push(6, 0); push(6, 6); push(3, 6); push(3, 3); push(3, 3);
        bus.enable = 1'b1;
        tick_n(9);
        bus.div_ratio = 8'd3;
        bus.div_load  = 1'b1;
        tick_n(1);
        bus.div_load  = 1'b0;
        tick_n(2);
        check("chg_before_wrap", int'(bus.cur_ratio), 6);
        tick_n(1);
        check("chg_after_wrap", int'(bus.cur_ratio), 3);
        tick_n(6);
        bus.enable = 1'b0;
        tick_n(5);
        expect_idle("chg");

        // N=4 running, load 5 on the wrap edge
        load_ratio(4);
        push(4, 0); push(4, 4); push(4, 4); push(5, 4); push(5, 5);
        bus.enable = 1'b1;
        tick_n(8);
        bus.div_ratio = 8'd5;
        bus.div_load  = 1'b1;
        tick_n(1);
        bus.div_load  = 1'b0;
        check("wrapload_deferred", int'(bus.cur_ratio), 4);
        tick_n(9);
        bus.enable = 1'b0;
        tick_n(6);
        expect_idle("wrapload");

        // N=4 running, rejected loads of 0 and 1
        load_ratio(4);
        push(4, 0); push(4, 4); push(4, 4); push(4, 4);
        bus.enable = 1'b1;
        tick_n(2);
        for (int r = 0; r < 2; r++) begin
            bus.div_ratio = WIDTH'(r);
            bus.div_load  = 1'b1;
            tick_n(1);
            bus.div_load  = 1'b0;
            check("load_err_pulse", int'(bus.load_err), 1);
            tick_n(1);
            check("load_err_clear", int'(bus.load_err), 0);
            if (r == 0) tick_n(2);
        end
        tick_n(5);
        bus.enable = 1'b0;
        tick_n(6);
        check("bad_load_ratio", int'(bus.cur_ratio), 4);
        expect_idle("bad_load");

        // N=7, drop enable at cnt=1: period completes, active falls at wrap
        load_ratio(7);
        push(7, 0);
        bus.enable = 1'b1;
        tick_n(2);
        bus.enable = 1'b0;
        tick_n(5);
        check("stop_active_before_wrap", int'(bus.active), 1);
        tick_n(1);
        check("stop_active_after_wrap", int'(bus.active), 0);
        check("stop_clk_out", int'(bus.clk_out), 0);
        tick_n(2);
        expect_idle("stop");

        // N=7, drop at cnt=1 and re-raise at cnt=4: no gap
        push(7, 0); push(7, 7); push(7, 7);
        bus.enable = 1'b1;
        tick_n(2);
        bus.enable = 1'b0;
        tick_n(3);
        bus.enable = 1'b1;
        tick_n(3);
        check("resume_active", int'(bus.active), 1);
        tick_n(7);
        bus.enable = 1'b0;
        tick_n(8);
        expect_idle("resume");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
